sr_flag_arbiter: RTL and testbench

Shared controller for a bank of set/reset flag bits with SR flip-flop semantics. Several requesters issue set, clear or hold commands against individual flags. A round-robin arbiter serializes them, granting one command per cycle. Sits between software/FSM requesters and the status-flag register bank, replacing per-flag ad-hoc SR drivers.

---
 rtl/sr_flag_arbiter.sv | 130 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: bank of SR flag bits shared by NREQ requesters through a
// round-robin arbiter. One command (hold / clear / set) is granted per cycle.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   clear_all_i    bulk clear of every flag; blocks grants that cycle
//   req_valid_i    per-requester command valid
//   req_op_i       per-requester {s,r}, requester i at [2i+1:2i]
//   req_idx_i      per-requester flag index, requester i at [IDXW*i +: IDXW]
//   req_ready_o    one-hot combinational grant
//   flags_o        registered flag bank
//   ack_valid_o    one-cycle pulse after each transfer
//   ack_id_o       requester of the acked command
//   ack_prev_o     flag value before the acked command (0 if out of range)
//   err_o          sticky illegal-op / out-of-range indicator
module sr_flag_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NFLAGS = 8,
  localparam int unsigned IDXW  = $clog2(NFLAGS),
  localparam int unsigned IdW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_all_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [2*NREQ-1:0]    req_op_i,
  input  logic [IDXW*NREQ-1:0] req_idx_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NFLAGS-1:0]    flags_o,
  output logic                 ack_valid_o,
  output logic [IdW-1:0]       ack_id_o,
  output logic                 ack_prev_o,
  output logic                 err_o
);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic              ack_valid_q, ack_valid_d;
  logic [IdW-1:0]    ack_id_q, ack_id_d;
  logic              ack_prev_q, ack_prev_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   gnt;
  logic [IdW-1:0]    gnt_id;
  logic              found;
  logic [1:0]        sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic              in_range;
  logic              xfer;
  int unsigned       cand;

  // Round-robin search starting at ptr_q; first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found   = 1'b0;
    sel_op  = '0;
    sel_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid_i[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_id      = IdW'(cand);
        sel_op      = req_op_i[2*cand +: 2];
        sel_idx     = req_idx_i[IDXW*cand +: IDXW];
      end
    end
    // Reset and bulk clear both suppress the grant entirely.
    if (!rstn || clear_all_i) begin
      gnt   = '0;
      found = 1'b0;
    end
  end

  assign xfer     = found;
  assign in_range = int'(sel_idx) < NFLAGS;

  always_comb begin
    flags_d     = flags_q;
    ptr_d       = ptr_q;
    ack_valid_d = 1'b0;
    ack_id_d    = ack_id_q;
    ack_prev_d  = ack_prev_q;
    err_d       = err_q;
    if (clear_all_i) begin
      flags_d = '0;
    end else if (xfer) begin
      ptr_d       = IdW'((int'(gnt_id) + 1) % NREQ);
      ack_valid_d = 1'b1;
      ack_id_d    = gnt_id;
      ack_prev_d  = in_range ? flags_q[sel_idx] : 1'b0;
      if (in_range) begin
        unique case (sel_op)
          2'b10:   flags_d[sel_idx] = 1'b1;
          2'b01:   flags_d[sel_idx] = 1'b0;
          default: flags_d[sel_idx] = flags_q[sel_idx];
        endcase
      end
      if (!in_range || sel_op == 2'b11) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      flags_q     <= '0;
      ptr_q       <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      ack_prev_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      ptr_q       <= ptr_d;
      ack_valid_q <= ack_valid_d;
      ack_id_q    <= ack_id_d;
      ack_prev_q  <= ack_prev_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = gnt;
  assign flags_o     = flags_q;
  assign ack_valid_o = ack_valid_q;
  assign ack_id_o    = ack_id_q;
  assign ack_prev_o  = ack_prev_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter (NREQ=4, NFLAGS=6 so that
// out-of-range indices 6 and 7 are reachable).
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;

  logic            clk;
  logic            rstn;
  logic            clear_all;
  logic [NR-1:0]   req_valid;
  logic [2*NR-1:0] req_op;
  logic [IW*NR-1:0] req_idx;
  logic [NR-1:0]   req_ready;
  logic [NF-1:0]   flags;
  logic            ack_valid;
  logic [1:0]      ack_id;
  logic            ack_prev;
  logic            err;

  sr_flag_arbiter #(.NREQ(NR), .NFLAGS(NF)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clear_all_i (clear_all),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_idx_i   (req_idx),
    .req_ready_o (req_ready),
    .flags_o     (flags),
    .ack_valid_o (ack_valid),
    .ack_id_o    (ack_id),
    .ack_prev_o  (ack_prev),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flags as an array of bits, pointer as an integer.
  bit m_flags[NF];
  int m_ptr;
  bit m_ack;
  int m_id;
  bit m_prev;
  bit m_err;
  logic [NR-1:0] rdy_seen;

  function automatic logic [NF-1:0] m_flag_vec();
    logic [NF-1:0] v;
    for (int i = 0; i < NF; i++) v[i] = m_flags[i];
    return v;
  endfunction

  function automatic int m_pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  // One clock cycle: drive, check grant before the edge, advance model,
  // check registered outputs after the edge.
  task automatic step(input logic r, input logic c, input logic [NR-1:0] v,
                      input logic [2*NR-1:0] op, input logic [IW*NR-1:0] ix);
    int g;
    int o;
    int id;
    logic [NR-1:0] exp_rdy;
    rstn = r; clear_all = c; req_valid = v; req_op = op; req_idx = ix;
    #1;
    g = m_pick(v);
    exp_rdy = '0;
    if (r && !c && g >= 0) exp_rdy[g] = 1'b1;
    rdy_seen = req_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    m_ack = 0;
    if (!r) begin
      foreach (m_flags[i]) m_flags[i] = 0;
      m_ptr = 0; m_id = 0; m_prev = 0; m_err = 0;
    end else if (c) begin
      foreach (m_flags[i]) m_flags[i] = 0;
    end else if (g >= 0) begin
      o  = int'(op[2*g +: 2]);
      id = int'(ix[IW*g +: IW]);
      m_ack = 1; m_id = g;
      m_prev = (id < NF) ? m_flags[id] : 1'b0;
      if (id >= NF || o == 3) m_err = 1;
      else if (o == 2) m_flags[id] = 1;
      else if (o == 1) m_flags[id] = 0;
      m_ptr = (g + 1) % NR;
    end
    #1;
    chk("flags", 64'(flags), 64'(m_flag_vec()));
    chk("ack_valid", 64'(ack_valid), 64'(m_ack));
    if (m_ack || !r) begin
      chk("ack_id", 64'(ack_id), 64'(m_id));
      chk("ack_prev", 64'(ack_prev), 64'(m_prev));
    end
    chk("err", 64'(err), 64'(m_err));
  endtask

  typedef struct {
    logic        rstn;
    logic        clr;
    logic [3:0]  valid;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [3:0]  e_rdy;
    logic [5:0]  e_flags;
    logic        e_ack;
    logic [1:0]  e_id;
    logic        e_prev;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic r, logic c, logic [3:0] v, logic [7:0] op,
                              logic [11:0] ix, logic [3:0] rd, logic [5:0] fl,
                              logic a, logic [1:0] id, logic p, logic e);
    vec_t t;
    t.rstn = r; t.clr = c; t.valid = v; t.op = op; t.idx = ix; t.e_rdy = rd;
    t.e_flags = fl; t.e_ack = a; t.e_id = id; t.e_prev = p; t.e_err = e;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    rstn = 1'b0; clear_all = 1'b0; req_valid = '0; req_op = '0; req_idx = '0;
    m_ptr = 0; m_ack = 0; m_id = 0; m_prev = 0; m_err = 0;
    foreach (m_flags[i]) m_flags[i] = 0;

    tbl[0]  = mk(0, 0, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0, 0);
    // requester 1 sets idx 3
    tbl[1]  = mk(1, 0, 4'h2, 8'h08, 12'h018, 4'h2, 6'h08, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0, 0);
    // fairness with hold ops
    tbl[3]  = mk(1, 0, 4'hF, 8'h00, 12'h000, 4'h1, 6'h00, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 4'hF, 8'h00, 12'h000, 4'h2, 6'h00, 1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 4'hF, 8'h00, 12'h000, 4'h4, 6'h00, 1, 2, 0, 0);
    tbl[6]  = mk(1, 0, 4'hF, 8'h00, 12'h000, 4'h8, 6'h00, 1, 3, 0, 0);
    tbl[7]  = mk(1, 0, 4'hF, 8'h00, 12'h000, 4'h1, 6'h00, 1, 0, 0, 0);
    // SR sequence on idx 5 by requester 0: set, hold, clear, illegal
    tbl[8]  = mk(1, 0, 4'h1, 8'h02, 12'h005, 4'h1, 6'h20, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 4'h1, 8'h00, 12'h005, 4'h1, 6'h20, 1, 0, 1, 0);
    tbl[10] = mk(1, 0, 4'h1, 8'h01, 12'h005, 4'h1, 6'h00, 1, 0, 1, 0);
    tbl[11] = mk(1, 0, 4'h1, 8'h03, 12'h005, 4'h1, 6'h00, 1, 0, 0, 1);
    tbl[12] = mk(1, 0, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0, 0);
    // set at out-of-range idx 7
    tbl[14] = mk(1, 0, 4'h1, 8'h02, 12'h007, 4'h1, 6'h00, 1, 0, 0, 1);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rstn, tbl[i].clr, tbl[i].valid, tbl[i].op, tbl[i].idx);
      chk($sformatf("tbl%0d.rdy", i), 64'(rdy_seen), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.flags", i), 64'(flags), 64'(tbl[i].e_flags));
      chk($sformatf("tbl%0d.ack", i), 64'(ack_valid), 64'(tbl[i].e_ack));
      if (tbl[i].e_ack || !tbl[i].rstn) begin
        chk($sformatf("tbl%0d.id", i), 64'(ack_id), 64'(tbl[i].e_id));
        chk($sformatf("tbl%0d.prev", i), 64'(ack_prev), 64'(tbl[i].e_prev));
      end
      chk($sformatf("tbl%0d.err", i), 64'(err), 64'(tbl[i].e_err));
    end

    // clear_all collision: fill flags, then requester 2 valid with clear_all
    for (int i = 0; i < NF; i++) step(1, 0, 4'h1, 8'h02, 12'(i));
    chk("fill.flags", 64'(flags), 64'h3F);
    step(1, 1, 4'h4, 8'h00, 12'h000);
    chk("clr.rdy", 64'(rdy_seen), 64'h0);
    chk("clr.flags", 64'(flags), 64'h0);
    chk("clr.ack", 64'(ack_valid), 64'h0);
    step(1, 0, 4'h4, 8'h00, 12'h000);
    chk("clr.after.rdy", 64'(rdy_seen), 64'h4);
    chk("clr.after.id", 64'(ack_id), 64'h2);

    // reset coincident with requester 3 set on idx 0
    step(0, 0, 4'h8, 8'h80, 12'h000);
    chk("rst.rdy", 64'(rdy_seen), 64'h0);
    chk("rst.flags", 64'(flags), 64'h0);
    chk("rst.ack", 64'(ack_valid), 64'h0);
    step(1, 0, 4'h9, 8'h00, 12'h000);
    chk("rst.ptr0", 64'(rdy_seen), 64'h1);
    step(1, 0, 4'h9, 8'h00, 12'h000);
    chk("rst.next3", 64'(rdy_seen), 64'h8);

    // back-to-back same-flag hazard: set then clear idx 2 by requesters 0,1
    step(1, 0, 4'h1, 8'h02, 12'o0002);
    step(1, 0, 4'h2, 8'h04, 12'o0020);
    chk("b2b.prev", 64'(ack_prev), 64'h1);
    chk("b2b.flags", 64'(flags), 64'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 11) == 0),
           NR'($urandom), (2*NR)'($urandom), (IW*NR)'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
